// File: rtl/vga_fb_scanout_if.sv
// Frame-buffer read port: scanout issues address/strobe, external synchronous RAM returns a palette index.
interface vga_fb_scanout_if #(
  parameter int AW = 17
);
  logic [AW-1:0] fb_addr;
  logic          fb_rd;
  logic [3:0]    fb_data;

  modport master (output fb_addr, fb_rd, input fb_data);
  modport slave  (input fb_addr, fb_rd, output fb_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// Frame-buffer scanout: scaled address generation, palette lookup, and sync/enable delay matching
// so RGB and syncs leave aligned MEM_LAT+2 cycles after the sync generator.
module vga_fb_scanout #(
  parameter int   H_PIXELS   = 640,
  parameter int   V_PIXELS   = 480,
  parameter int   SCALE_LOG2 = 1,
  parameter int   MEM_LAT    = 2,
  parameter logic H_POL      = 1'b0,
  parameter logic V_POL      = 1'b0,
  localparam int  FB_W       = H_PIXELS >> SCALE_LOG2,
  localparam int  FB_H       = V_PIXELS >> SCALE_LOG2,
  localparam int  AW         = $clog2(FB_W * FB_H),
  localparam int  CW         = $clog2(H_PIXELS),
  localparam int  RW         = $clog2(V_PIXELS)
) (
  input  logic                    pixel_clk,
  input  logic                    reset_n,
  input  logic                    h_sync_in,
  input  logic                    v_sync_in,
  input  logic                    disp_ena_in,
  input  logic [CW-1:0]           column,
  input  logic [RW-1:0]           row,
  vga_fb_scanout_if.master        fb,
  input  logic                    pal_we,
  input  logic [3:0]              pal_idx,
  input  logic [11:0]             pal_rgb,
  output logic [3:0]              vga_r,
  output logic [3:0]              vga_g,
  output logic [3:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    frame_start,
  output logic                    vblank_start
);

  localparam int L = MEM_LAT + 2;

  logic [L-1:0]  hs_sr, vs_sr, fs_sr;
  // The last enable stage is implicit: the RGB register is already zero whenever it would be low.
  logic [L-2:0]  de_sr;
  logic [AW-1:0] line_base, base_now;
  logic [RW-1:0] row_prev;
  logic [11:0]   palette [16];
  logic [11:0]   rgb;
  logic          fs_in, vb_in;

  always_comb begin
    base_now = line_base;
    if (row == '0 && row_prev != '0)
      base_now = '0;
    else if ((row >> SCALE_LOG2) != (row_prev >> SCALE_LOG2))
      base_now = line_base + AW'(FB_W);
  end

  assign fs_in = disp_ena_in && row == '0 && column == '0;
  assign vb_in = disp_ena_in && row == RW'(V_PIXELS - 1) && column == CW'(H_PIXELS - 1);

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_base    <= '0;
      row_prev     <= '0;
      fb.fb_addr   <= '0;
      fb.fb_rd     <= 1'b0;
      hs_sr        <= {L{~H_POL}};
      vs_sr        <= {L{~V_POL}};
      de_sr        <= '0;
      fs_sr        <= '0;
      vblank_start <= 1'b0;
    end else begin
      if (disp_ena_in) begin
        line_base  <= base_now;
        row_prev   <= row;
        fb.fb_addr <= base_now + AW'(column >> SCALE_LOG2);
      end
      fb.fb_rd     <= disp_ena_in;
      hs_sr        <= {hs_sr[L-2:0], h_sync_in};
      vs_sr        <= {vs_sr[L-2:0], v_sync_in};
      de_sr        <= {de_sr[L-3:0], disp_ena_in};
      fs_sr        <= {fs_sr[L-2:0], fs_in};
      vblank_start <= vb_in;
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++)
        palette[i] <= {3{i[3:0]}};
    end else if (pal_we) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  // Stage P samples the palette before any same-cycle write lands, so a colliding read sees the old entry.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n)
      rgb <= '0;
    else
      rgb <= de_sr[L-2] ? palette[fb.fb_data] : '0;
  end

  assign {vga_r, vga_g, vga_b} = rgb;
  assign vga_hs      = hs_sr[L-1];
  assign vga_vs      = vs_sr[L-1];
  assign frame_start = fs_sr[L-1];

endmodule
